// File: rtl/cpup_pkg.sv
// Shared microcode definitions: widths, control-word field positions, hold word
// and the loader FSM state encoding.
package cpup_pkg;

  localparam int unsigned MC_ADDR_W = 11;
  localparam int unsigned MC_DATA_W = 26;
  localparam int unsigned LOAD_W    = 16;

  // Control word field positions
  localparam int unsigned MC_ACB_LSB     = 0;
  localparam int unsigned MC_ACB_MSB     = 8;
  localparam int unsigned MC_ICB_LSB     = 9;
  localparam int unsigned MC_ICB_MSB     = 11;
  localparam int unsigned MC_MCB_LSB     = 12;
  localparam int unsigned MC_MCB_MSB     = 15;
  localparam int unsigned MC_REG_IN_LSB  = 18;
  localparam int unsigned MC_REG_IN_MSB  = 19;
  localparam int unsigned MC_REG_OUT_LSB = 20;
  localparam int unsigned MC_REG_OUT_MSB = 21;
  localparam int unsigned MC_RST_CNT_BIT = 22;

  // Only the counter-reset bit is set, parking the sequencer at microstep 0
  localparam logic [MC_DATA_W-1:0] HOLD_WORD = 26'h040_0000;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ADDR,
    ST_COUNT,
    ST_LOW,
    ST_HIGH
  } mc_state_e;

endpackage

// File: rtl/microcode_store_if.sv
// Host-side word-serial load port of the microcode store.
interface microcode_store_if;
  logic        load_en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        load_error;
  logic        busy;

  modport master (
    output load_en, load_valid, load_data,
    input  load_ready, load_done, load_error, busy
  );

  modport slave (
    input  load_en, load_valid, load_data,
    output load_ready, load_done, load_error, busy
  );
endinterface

// File: rtl/microcode_store_mc_ram.sv
// Microcode array: one synchronous write port, one asynchronous read port, no reset.
module mc_ram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 26
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/microcode_store.sv
// Microcode store with word-serial host loader; drives the hold word to the
// sequencer whenever a load session is active.
module microcode_store
  import cpup_pkg::*;
#(
  parameter int unsigned          ADDR_W    = MC_ADDR_W,
  parameter int unsigned          DATA_W    = MC_DATA_W,
  parameter logic [DATA_W-1:0]    HOLD_WORD = cpup_pkg::HOLD_WORD
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  mc_addr,
  output logic [DATA_W-1:0]  microcode,
  microcode_store_if.slave   ld
);

  localparam int unsigned HI_W = DATA_W - LOAD_W;
  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t DEPTH = cnt_t'(1) << ADDR_W;

  mc_state_e         state, state_nx;
  logic [ADDR_W-1:0] ptr;
  cnt_t              remaining;
  logic [LOAD_W-1:0] low_q;
  logic              armed;
  logic              done_q;
  logic              error_q;

  logic              hs;
  logic              start;
  logic              wr_en;
  logic              last;
  cnt_t              count_raw;
  cnt_t              count_in;
  logic              count_err;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_data;

  assign hs      = ld.load_valid & ld.load_ready;
  assign wr_data = {ld.load_data[HI_W-1:0], low_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nx;
  end

  // Dropping load_en aborts from any load state and suppresses that cycle's write
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    wr_en    = 1'b0;
    last     = 1'b0;
    if (state == ST_RUN) begin
      if (ld.load_en && armed) begin
        start    = 1'b1;
        state_nx = ST_ADDR;
      end
    end else if (!ld.load_en) begin
      state_nx = ST_RUN;
    end else if (hs) begin
      unique case (state)
        ST_ADDR:  state_nx = ST_COUNT;
        ST_COUNT: state_nx = ST_LOW;
        ST_LOW:   state_nx = ST_HIGH;
        ST_HIGH: begin
          wr_en = 1'b1;
          if (remaining == cnt_t'(1)) begin
            last     = 1'b1;
            state_nx = ST_RUN;
          end else begin
            state_nx = ST_LOW;
          end
        end
        default:  state_nx = ST_RUN;
      endcase
    end
  end

  // A count of zero means a full store; anything above a full store wraps
  always_comb begin
    count_raw = ld.load_data[ADDR_W:0];
    count_in  = count_raw;
    count_err = 1'b0;
    if (count_raw == '0) begin
      count_in = DEPTH;
    end else if (count_raw > DEPTH) begin
      count_in  = {1'b0, count_raw[ADDR_W-1:0]};
      count_err = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      remaining <= '0;
      low_q     <= '0;
      armed     <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= last;
      // A finished session must see load_en low once before another may start
      if (!ld.load_en)  armed <= 1'b1;
      else if (start)   armed <= 1'b0;
      if (start) error_q <= 1'b0;
      if (hs && ld.load_en) begin
        unique case (state)
          ST_ADDR: begin
            ptr <= ld.load_data[ADDR_W-1:0];
            if (|ld.load_data[LOAD_W-1:ADDR_W]) error_q <= 1'b1;
          end
          ST_COUNT: begin
            remaining <= count_in;
            if (count_err) error_q <= 1'b1;
          end
          ST_LOW:  low_q <= ld.load_data;
          ST_HIGH: begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - cnt_t'(1);
            if (|ld.load_data[LOAD_W-1:HI_W]) error_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  mc_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (ptr),
    .wdata (wr_data),
    .raddr (mc_addr),
    .rdata (rd_data)
  );

  assign ld.busy       = (state != ST_RUN);
  assign ld.load_ready = (state != ST_RUN);
  assign ld.load_done  = done_q;
  assign ld.load_error = error_q;
  assign microcode     = ld.busy ? HOLD_WORD : rd_data;

endmodule

// File: tb/tb_microcode_store.sv
// Scoreboard bench for microcode_store: loaded entries are queued as they are
// driven and read back through mc_addr once the store is in RUN.
module tb_microcode_store;
  import cpup_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [10:0] mc_addr;
  logic [25:0] microcode;

  microcode_store_if ld ();

  microcode_store #(
    .ADDR_W    (11),
    .DATA_W    (26),
    .HOLD_WORD (26'h040_0000)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mc_addr   (mc_addr),
    .microcode (microcode),
    .ld        (ld)
  );

  always #5 clock = ~clock;

  localparam logic [25:0] HOLD = 26'h040_0000;

  typedef struct {
    logic [10:0] addr;
    logic [25:0] data;
  } entry_t;

  entry_t      sb[$];
  logic [25:0] model [logic [10:0]];
  int          errors   = 0;
  int          checks   = 0;
  int          done_cnt = 0;

  always @(negedge clock) if (ld.load_done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [15:0] w);
    ld.load_valid = 1'b1;
    ld.load_data  = w;
    @(posedge clock); #1;
    ld.load_valid = 1'b0;
  endtask

  task automatic begin_session();
    ld.load_en = 1'b1;
    step();
  endtask

  task automatic end_session();
    ld.load_en = 1'b0;
    step();
  endtask

  task automatic load_entry(input logic [10:0] a, input logic [25:0] d);
    entry_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
    model[a] = d;
    send(d[15:0]);
    send({6'b0, d[25:16]});
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    ld.load_en    = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_data  = '0;
    mc_addr       = '0;
    step(2);
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ld.load_ready); end
    checks++; if (ld.load_done  !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", ld.load_done); end
    checks++; if (ld.load_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", ld.load_error); end
    checks++; if (ld.busy       !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ld.busy); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    mc_addr = 11'h010;
    begin_session();
    checks++; if (ld.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", ld.busy); end
    checks++; if (microcode !== HOLD) begin errors++; $display("FAIL basic_hold_start: got %h want %h", microcode, HOLD); end
    send(16'h0010);
    send(16'h0001);
    checks++; if (microcode !== HOLD) begin errors++; $display("FAIL basic_hold_mid: got %h want %h", microcode, HOLD); end
    checks++; if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_mid: got %b want 1", ld.load_ready); end
    load_entry(11'h010, 26'h155BEEF);
    checks++; if (ld.load_done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse: got %b want 1", ld.load_done); end
    checks++; if (ld.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", ld.busy); end
    step(3);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (ld.busy !== 1'b0) begin errors++; $display("FAIL basic_no_restart: busy got %b want 0", ld.busy); end
    checks++; if (ld.load_error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", ld.load_error); end
    end_session();
    while (sb.size() > 0) begin
      entry_t e;
      e = sb.pop_front();
      mc_addr = e.addr; #1;
      checks++; if (microcode !== e.data) begin errors++; $display("FAIL basic_readback @%h: got %h want %h", e.addr, microcode, e.data); end
    end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    begin_session();
    send(16'h07FF);
    send(16'h0002);
    load_entry(11'h7FF, 26'h2A51234);
    load_entry(11'h000, 26'h1C0FFEE);
    step();
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); end
    end_session();
    while (sb.size() > 0) begin
      entry_t e;
      e = sb.pop_front();
      mc_addr = e.addr; #1;
      checks++; if (microcode !== e.data) begin errors++; $display("FAIL wrap_readback @%h: got %h want %h", e.addr, microcode, e.data); end
    end
  endtask

  task automatic test_abort();
    int     d0;
    entry_t u;
    begin_session();
    send(16'h0103);
    send(16'h0001);
    load_entry(11'h103, 26'h3000ABC);
    end_session();
    sb.delete();
    d0 = done_cnt;
    begin_session();
    send(16'h0100);
    send(16'h0000);
    for (int unsigned i = 0; i < 3; i++) load_entry(11'h100 + 11'(i), 26'h1230000 + 26'(i * 17));
    send(16'hDEAD);
    ld.load_en    = 1'b0;
    ld.load_valid = 1'b1;
    ld.load_data  = 16'h0077;
    @(posedge clock); #1;
    ld.load_valid = 1'b0;
    checks++; if (ld.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", ld.busy); end
    step(2);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    u.addr = 11'h103;
    u.data = model[11'h103];
    sb.push_back(u);
    while (sb.size() > 0) begin
      entry_t e;
      e = sb.pop_front();
      mc_addr = e.addr; #1;
      checks++; if (microcode !== e.data) begin errors++; $display("FAIL abort_readback @%h: got %h want %h", e.addr, microcode, e.data); end
    end
  endtask

  task automatic test_error();
    int     d0;
    entry_t e1;
    begin_session();
    send(16'h0200);
    send(16'h0001);
    send(16'h1234);
    send(16'hFC01);
    e1.addr = 11'h200; e1.data = 26'h0011234;
    sb.push_back(e1); model[e1.addr] = e1.data;
    checks++; if (ld.load_error !== 1'b1) begin errors++; $display("FAIL error_high_set: got %b want 1", ld.load_error); end
    step(3);
    end_session();
    checks++; if (ld.load_error !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b want 1", ld.load_error); end
    begin_session();
    checks++; if (ld.load_error !== 1'b0) begin errors++; $display("FAIL error_clear_on_start: got %b want 0", ld.load_error); end
    d0 = done_cnt;
    send(16'h0B00);
    checks++; if (ld.load_error !== 1'b1) begin errors++; $display("FAIL error_addr_set: got %b want 1", ld.load_error); end
    send(16'h0801);
    send(16'h5555);
    send(16'h0002);
    e1.addr = 11'h300; e1.data = 26'h0025555;
    sb.push_back(e1); model[e1.addr] = e1.data;
    step();
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL error_count_wrap_done: got %0d want 1", done_cnt - d0); end
    end_session();
    while (sb.size() > 0) begin
      entry_t e;
      e = sb.pop_front();
      mc_addr = e.addr; #1;
      checks++; if (microcode !== e.data) begin errors++; $display("FAIL error_readback @%h: got %h want %h", e.addr, microcode, e.data); end
    end
  endtask

  task automatic test_random();
    logic [15:0] words[$];
    int unsigned idx = 0;
    int unsigned guard = 0;
    logic [25:0] d;
    entry_t      u;
    begin_session();
    send(16'h0504);
    send(16'h0001);
    load_entry(11'h504, 26'h0ABCDEF);
    end_session();
    sb.delete();
    words.push_back(16'h0500);
    words.push_back(16'h0005);
    for (int unsigned i = 0; i < 4; i++) begin
      d = 26'($urandom);
      words.push_back(d[15:0]);
      words.push_back({6'b0, d[25:16]});
      u.addr = 11'h500 + 11'(i); u.data = d;
      sb.push_back(u); model[u.addr] = d;
    end
    words.push_back(16'h4444);
    begin_session();
    while (idx < words.size() && guard < 1000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      ld.load_valid = v;
      ld.load_data  = v ? words[idx] : 16'($urandom);
      @(posedge clock); #1;
      if (v) idx++;
      guard++;
    end
    ld.load_valid = 1'b0;
    checks++; if (idx != words.size()) begin errors++; $display("FAIL random_stream_timeout: consumed %0d want %0d", idx, words.size()); end
    ld.load_en    = 1'b0;
    ld.load_valid = 1'b1;
    ld.load_data  = 16'h0155;
    @(posedge clock); #1;
    ld.load_valid = 1'b0;
    step();
    u.addr = 11'h504; u.data = model[11'h504];
    sb.push_back(u);
    while (sb.size() > 0) begin
      entry_t e;
      e = sb.pop_front();
      mc_addr = e.addr; #1;
      checks++; if (microcode !== e.data) begin errors++; $display("FAIL random_readback @%h: got %h want %h", e.addr, microcode, e.data); end
    end
  endtask

  task automatic test_reset_mid();
    begin_session();
    send(16'h0400);
    send(16'h0002);
    send(16'h9999);
    #2;
    reset_n = 1'b0;
    mc_addr = 11'h010;
    #1;
    checks++; if (ld.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", ld.busy); end
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", ld.load_ready); end
    checks++; if (ld.load_error !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b want 0", ld.load_error); end
    checks++; if (microcode !== model[11'h010]) begin errors++; $display("FAIL rstmid_read: got %h want %h", microcode, model[11'h010]); end
    ld.load_en = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    foreach (model[a]) begin
      entry_t u;
      u.addr = a; u.data = model[a];
      sb.push_back(u);
    end
    while (sb.size() > 0) begin
      entry_t e;
      e = sb.pop_front();
      mc_addr = e.addr; #1;
      checks++; if (microcode !== e.data) begin errors++; $display("FAIL rstmid_readback @%h: got %h want %h", e.addr, microcode, e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_error();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microcode_store.md
# microcode_store

Microcode memory and loader serving the execution module's microcode fetch interface. It returns the 26-bit control word for every 11-bit `mc_addr` the sequencer presents. A word-serial loader fills the store from a 16-bit host port after power-up. While a load is in progress, it drives a hold word that keeps the sequencer parked at microstep 0.

## Interface
- `ADDR_W`, 11: microcode address width; depth is 2^ADDR_W.
- `DATA_W`, 26: microcode word width.
- `HOLD_WORD`, 26'h040_0000: word driven while loading; only bit 22 (counter reset) is set.
- `clock`  in  1: single clock; all state updates on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `mc_addr`  in  11: {instr[15:12], m1, m2, attached, index[3:0]} from the sequencer.
- `microcode`  out  26: control word for `mc_addr`.
- `load_en`  in  1: level; high requests and holds a load session.
- `load_valid`  in  1: host word valid.
- `load_data`  in  16: host word.
- `load_ready`  out  1: store accepts a word this cycle.
- `load_done`  out  1: one-cycle pulse when a session completes normally.
- `load_error`  out  1: sticky format error; cleared on next session start.
- `busy`  out  1: high in any non-RUN state.

## Operation
- FSM states: RUN, ADDR, COUNT, LOW, HIGH. Reset state is RUN.
- A handshake is `load_valid & load_ready` at posedge.
- RUN:
  - `microcode = mem[mc_addr]` combinationally (async read).
  - `load_ready = 0`.
  - `load_en = 1` -> ADDR; clears `load_error`.
- ADDR:
  - Handshake -> `ptr <= load_data[10:0]`; go to COUNT.
  - Nonzero `load_data[15:11]` sets `load_error`; the word is still used.
- COUNT:
  - Handshake -> `remaining <= load_data[11:0]`; value 0 means 2048.
  - Values above 2048 set `load_error` and are taken mod 2048.
  - Go to LOW.
- LOW:
  - Handshake -> `low_q <= load_data`; go to HIGH.
- HIGH:
  - Handshake -> `mem[ptr] <= {load_data[9:0], low_q}`.
  - `ptr <= ptr+1`, wrapping 2047->0.
  - `remaining <= remaining-1`.
  - If `remaining` was 1 -> RUN with `load_done = 1` for one cycle; else -> LOW.
  - Nonzero `load_data[15:10]` sets `load_error`; the entry is still written truncated.
- `load_ready = 1` in ADDR, COUNT, LOW, HIGH.
- `load_en = 0` in any load state -> RUN next cycle:
  - No write that cycle, even if a handshake is present (abort wins).
  - No `load_done`.
  - Already-written entries remain.
- In every non-RUN state, `microcode = HOLD_WORD` regardless of `mc_addr`.
- Memory has no reset. Contents survive `reset_n` and are undefined at power-up until loaded.
- `load_en` still high on return to RUN after done -> no restart. A new session requires `load_en` low for at least one cycle.

## Timing
- Reset values:
  - state RUN, `ptr` 0, `remaining` 0, `low_q` 0.
  - `load_ready` 0, `load_done` 0, `load_error` 0, `busy` 0.
  - `microcode = mem[mc_addr]`.
- `reset_n` asserted mid-session -> immediate RUN. Partial writes are kept.
- Read latency is 0 cycles (combinational from `mc_addr`). The sequencer changes `mc_addr` on negedge, so the word is stable at the next posedge.
- A written entry is readable the cycle after the HIGH handshake.
- Minimum session length for N entries: 2 + 2N handshake cycles; `load_done` follows the final handshake edge.
- `busy` and HOLD_WORD take effect the cycle after `load_en` is sampled high in RUN.

## Structure
- Package `cpup_pkg`:
  - FSM state enum.
  - `HOLD_WORD`.
  - Microcode field positions: ACB [8:0], ICB [11:9], MCB [15:12], reg-in [19:18], reg-out [21:20], reset-counter [22].
  - `MC_ADDR_W`/`MC_DATA_W`.
- Sub-module `mc_ram`: 2^ADDR_W x DATA_W array, one synchronous write port, one async read port.
- The FSM and datapath stay in `microcode_store`.

## Test plan
- Reset, then `load_en=1` and words 0x0010, 0x0001, 0xBEEF, 0x0155:
  - `busy=1` and `microcode=040_0000` during the session.
  - `load_done` pulses once.
  - Then `mc_addr=0x010` yields 26'h155BEEF.
- Start address 0x7FF, count 2, two entries:
  - Data lands at 0x7FF and 0x000 (wrap).
- Count word 0x0000 with a `load_en` abort after 3 entries:
  - Entries 0..2 written, entry 3 untouched.
  - No `load_done`; RUN reads resume.
- HIGH word 0xFC01:
  - `load_error=1` and stays set.
  - Entry written with high bits 0x001.
  - Next session start clears `load_error`.
- `reset_n` pulsed low mid-LOW:
  - Outputs return to reset values immediately.
  - Previously loaded entries still read back unchanged.
- `load_valid` toggled randomly with backpressure-free `load_ready`:
  - Each word is consumed exactly once per handshake.
  - No write occurs on a cycle where `load_en` falls.
